// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit for the five-stage Y86-64 pipeline (F, D, E, M, W).
//
// Produces the per-stage stall/bubble controls for load/use hazards, mispredicted jumps,
// ret, exceptional status and multi-cycle data-memory accesses. A small IDLE/WAIT/ERR FSM
// sequences the M-stage data-memory handshake and declares a sticky memory error when an
// access is not acknowledged within MEM_TIMEOUT wait cycles.
//
// Parameters:
//   MEM_TIMEOUT  max WAIT cycles before a memory error (1..255)
//   CNT_W        width of the stall-cycle counter
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   D_icode                icode in D register
//   d_srcA, d_srcB         decode-stage sources (0xF = none)
//   E_icode, E_dstM        icode / memory destination in E register
//   e_cnd                  execute-stage condition result
//   M_icode, m_stat        icode in M register, memory-stage status
//   W_stat                 status in W register
//   dmem_ack               data memory completes access this cycle
//   dmem_req               data memory request
//   {F,D,E,M,W}_stall      hold the stage register
//   {D,E,M,W}_bubble       load a bubble into the stage register
//   halted                 sticky: pipeline frozen
//   mem_err                sticky: memory timeout occurred
//   stall_cnt              saturating count of cycles with F_stall=1

module pipe_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       D_icode,
   input  logic [3:0]       d_srcA,
   input  logic [3:0]       d_srcB,
   input  logic [3:0]       E_icode,
   input  logic [3:0]       E_dstM,
   input  logic             e_cnd,
   input  logic [3:0]       M_icode,
   input  logic [1:0]       m_stat,
   input  logic [1:0]       W_stat,
   input  logic             dmem_ack,
   output logic             dmem_req,
   output logic             F_stall,
   output logic             D_stall,
   output logic             D_bubble,
   output logic             E_stall,
   output logic             E_bubble,
   output logic             M_stall,
   output logic             M_bubble,
   output logic             W_stall,
   output logic             W_bubble,
   output logic             halted,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [1:0] StatAok  = 2'b00;

   localparam logic [3:0] IRmmovq = 4'h4;
   localparam logic [3:0] IMrmovq = 4'h5;
   localparam logic [3:0] IJxx    = 4'h7;
   localparam logic [3:0] ICall   = 4'h8;
   localparam logic [3:0] IRet    = 4'h9;
   localparam logic [3:0] IPushq  = 4'hA;
   localparam logic [3:0] IPopq   = 4'hB;
   localparam logic [3:0] RNone   = 4'hF;

   localparam logic [7:0]       TimeoutCnt = 8'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CntOne     = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {StIdle, StWait, StErr} state_e;

   state_e           state_q, state_d;
   logic [7:0]       wcnt_q, wcnt_d;
   logic             halted_q, halted_d;
   logic             mem_err_q, mem_err_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic loaduse, ret_p, mispred, m_mem, mem_wait, frz;

   // Hazard detection
   always_comb begin
      loaduse = (E_icode == IMrmovq || E_icode == IPopq) && (E_dstM != RNone) &&
                (E_dstM == d_srcA || E_dstM == d_srcB);
      ret_p   = (D_icode == IRet) || (E_icode == IRet) || (M_icode == IRet);
      mispred = (E_icode == IJxx) && !e_cnd;
      m_mem   = (M_icode == IRmmovq || M_icode == IMrmovq || M_icode == ICall ||
                 M_icode == IRet || M_icode == IPushq || M_icode == IPopq) &&
                (m_stat == StatAok);
      // Once in ERR the access is abandoned; the freeze holds the pipeline instead.
      mem_wait = m_mem && !dmem_ack && (state_q != StErr);
      frz      = halted_q || (W_stat != StatAok);
   end

   // Stage controls
   always_comb begin
      F_stall  = loaduse || ret_p || mem_wait || frz;
      D_stall  = loaduse || mem_wait || frz;
      D_bubble = !D_stall && (mispred || ret_p);
      E_stall  = mem_wait || frz;
      E_bubble = !E_stall && (mispred || loaduse);
      M_stall  = mem_wait || frz;
      M_bubble = !M_stall && ((m_stat != StatAok) || (W_stat != StatAok));
      W_stall  = frz;
      W_bubble = mem_wait && !frz;
   end

   // Memory handshake FSM and sticky state
   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      dmem_req    = 1'b0;
      halted_d    = halted_q || (W_stat != StatAok);
      mem_err_d   = mem_err_q;
      stall_cnt_d = stall_cnt_q;

      unique case (state_q)
         StIdle: begin
            dmem_req = m_mem && !halted_q;
            // An ack in the request cycle is a zero-wait access.
            if (dmem_req && !dmem_ack) begin
               state_d = StWait;
               wcnt_d  = 8'd1;
            end
         end
         StWait: begin
            dmem_req = 1'b1;
            if (dmem_ack) begin
               state_d = StIdle;
               wcnt_d  = 8'd0;
            end else if (wcnt_q == TimeoutCnt) begin
               state_d   = StErr;
               halted_d  = 1'b1;
               mem_err_d = 1'b1;
            end else begin
               wcnt_d = wcnt_q + 8'd1;
            end
         end
         StErr: begin
            dmem_req = 1'b0;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (F_stall && (stall_cnt_q != CntMax)) begin
         stall_cnt_d = stall_cnt_q + CntOne;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         wcnt_q      <= 8'd0;
         halted_q    <= 1'b0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         halted_q    <= halted_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign halted    = halted_q;
   assign mem_err   = mem_err_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl. Controls are compared as a packed vector:
// {dmem_req, F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble,
//  W_stall, W_bubble, halted, mem_err}.
module tb_pipe_ctrl;

   localparam int unsigned CntW = 4;

   logic            clk;
   logic            rst_n;
   logic [3:0]      D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
   logic            e_cnd;
   logic [1:0]      m_stat, W_stat;
   logic            dmem_ack;
   logic            dmem_req, F_stall, D_stall, D_bubble, E_stall, E_bubble;
   logic            M_stall, M_bubble, W_stall, W_bubble, halted, mem_err;
   logic [CntW-1:0] stall_cnt;

   int checks;
   int failures;

   // Control patterns
   localparam logic [11:0] CtlNone    = 12'b0000_0000_0000;
   localparam logic [11:0] CtlLoadUse = 12'b0110_0100_0000;
   localparam logic [11:0] CtlMispred = 12'b0001_0100_0000;
   localparam logic [11:0] CtlMemWait = 12'b1110_1010_0100;
   localparam logic [11:0] CtlReqOnly = 12'b1000_0000_0000;
   localparam logic [11:0] CtlErr     = 12'b0110_1010_1011;
   localparam logic [11:0] CtlWHalt   = 12'b0110_1010_1000;
   localparam logic [11:0] CtlHalted  = 12'b0110_1010_1010;
   localparam logic [11:0] CtlMBubble = 12'b0000_0001_0000;

   pipe_ctrl #(
      .MEM_TIMEOUT(4),
      .CNT_W      (CntW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .D_icode  (D_icode),
      .d_srcA   (d_srcA),
      .d_srcB   (d_srcB),
      .E_icode  (E_icode),
      .E_dstM   (E_dstM),
      .e_cnd    (e_cnd),
      .M_icode  (M_icode),
      .m_stat   (m_stat),
      .W_stat   (W_stat),
      .dmem_ack (dmem_ack),
      .dmem_req (dmem_req),
      .F_stall  (F_stall),
      .D_stall  (D_stall),
      .D_bubble (D_bubble),
      .E_stall  (E_stall),
      .E_bubble (E_bubble),
      .M_stall  (M_stall),
      .M_bubble (M_bubble),
      .W_stall  (W_stall),
      .W_bubble (W_bubble),
      .halted   (halted),
      .mem_err  (mem_err),
      .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] ctl();
      return {dmem_req, F_stall, D_stall, D_bubble, E_stall, E_bubble,
              M_stall, M_bubble, W_stall, W_bubble, halted, mem_err};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic defaults();
      D_icode  = 4'h1;
      d_srcA   = 4'hF;
      d_srcB   = 4'hF;
      E_icode  = 4'h1;
      E_dstM   = 4'hF;
      e_cnd    = 1'b1;
      M_icode  = 4'h1;
      m_stat   = 2'b00;
      W_stat   = 2'b00;
      dmem_ack = 1'b0;
   endtask

   // Advance one clock; inputs are changed 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      defaults();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b1;
      defaults();
      #2;
      do_reset();
      check_eq("reset_ctl", 32'(ctl()), 32'(CtlNone));
      check_eq("reset_cnt", 32'(stall_cnt), 32'd0);

      // Load/use
      E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; dmem_ack = 1'b1;
      #1;
      check_eq("loaduse_ctl", 32'(ctl()), 32'(CtlLoadUse));
      step();
      check_eq("loaduse_cnt", 32'(stall_cnt), 32'd1);

      // Mispredict, then correctly predicted jump
      defaults();
      E_icode = 4'h7; e_cnd = 1'b0; D_icode = 4'h6;
      #1;
      check_eq("mispred_ctl", 32'(ctl()), 32'(CtlMispred));
      e_cnd = 1'b1;
      #1;
      check_eq("taken_ctl", 32'(ctl()), 32'(CtlNone));
      step();
      check_eq("mispred_cnt", 32'(stall_cnt), 32'd1);

      // ret combined with load/use: D stalls, not bubbled
      defaults();
      D_icode = 4'h9; E_icode = 4'hB; E_dstM = 4'h4; d_srcB = 4'h4;
      #1;
      check_eq("ret_lu_ctl", 32'(ctl()), 32'(CtlLoadUse));
      step();
      check_eq("ret_lu_cnt", 32'(stall_cnt), 32'd2);

      // Memory wait: three stall cycles, ack on the fourth
      do_reset();
      M_icode = 4'h5;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_eq($sformatf("memwait_ctl%0d", i), 32'(ctl()), 32'(CtlMemWait));
         step();
      end
      dmem_ack = 1'b1;
      #1;
      check_eq("memack_ctl", 32'(ctl()), 32'(CtlReqOnly));
      check_eq("memack_cnt", 32'(stall_cnt), 32'd3);
      step();
      M_icode = 4'h1; dmem_ack = 1'b0;
      #1;
      check_eq("memidle_ctl", 32'(ctl()), 32'(CtlNone));
      // Zero-wait access from IDLE
      M_icode = 4'h5; dmem_ack = 1'b1;
      #1;
      check_eq("zerowait_ctl", 32'(ctl()), 32'(CtlReqOnly));
      step();
      M_icode = 4'h1; dmem_ack = 1'b0;
      #1;
      check_eq("zerowait_idle", 32'(ctl()), 32'(CtlNone));
      check_eq("zerowait_cnt", 32'(stall_cnt), 32'd3);

      // Timeout: IDLE request cycle plus 4 WAIT cycles, then ERR
      do_reset();
      M_icode = 4'h4;
      for (int i = 0; i < 5; i++) begin
         #1;
         check_eq($sformatf("timeout_wait%0d", i), 32'(ctl()), 32'(CtlMemWait));
         step();
      end
      check_eq("timeout_err", 32'(ctl()), 32'(CtlErr));
      for (int i = 0; i < 20; i++) step();
      check_eq("err_persist", 32'(ctl()), 32'(CtlErr));
      check_eq("cnt_saturate", 32'(stall_cnt), 32'd15);
      do_reset();
      check_eq("err_reset_ctl", 32'(ctl()), 32'(CtlNone));
      check_eq("err_reset_cnt", 32'(stall_cnt), 32'd0);

      // Reset during WAIT abandons the access
      M_icode = 4'h5;
      step();
      step();
      do_reset();
      check_eq("wait_reset_ctl", 32'(ctl()), 32'(CtlNone));

      // Halt via W status
      W_stat = 2'b01;
      #1;
      check_eq("whalt_ctl", 32'(ctl()), 32'(CtlWHalt));
      step();
      W_stat = 2'b00;
      #1;
      check_eq("halted_ctl", 32'(ctl()), 32'(CtlHalted));
      // No memory request while halted
      M_icode = 4'h5;
      #1;
      check_eq("halted_noreq", 32'(ctl()), 32'(CtlHalted));
      step();
      check_eq("halted_persist", 32'(ctl()), 32'(CtlHalted));

      // Exceptional m_stat alone bubbles M without halting
      do_reset();
      m_stat = 2'b10;
      #1;
      check_eq("mstat_ctl", 32'(ctl()), 32'(CtlMBubble));
      step();
      check_eq("mstat_nohalt", 32'(halted), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
